sram_op_responder: RTL and testbench

Memory-side responder for the two-bit mem-op request interface (read `01`, write `11`, none `00`) driven by the Wishbone slave controller and by the compute core. It arbitrates the two requesters round-robin and drives a single-port OpenRAM-style SRAM macro. For each request it returns a one-cycle `*_opdone` pulse, and for reads the word read from the SRAM. It sits between the Wishbone/core requesters and the user-area SRAM.

---
 rtl/knight_mem_pkg.sv | 26 ++
 rtl/mem_rr_arb2.sv | 41 ++++
 rtl/sram_op_responder.sv | 198 +++++++++++++++++++
 tb/tb_sram_op_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_mem_pkg.sv
// Shared definitions for the mem-op responder: op encodings, FSM states, port indices.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: MEM_OP_* encodings, resp_state_t, PORT_WB/PORT_CORE, is_mem_req().
package knight_mem_pkg;

   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_READ  = 2'b01;
   localparam logic [1:0] MEM_OP_WRITE = 2'b11;

   localparam logic PORT_WB   = 1'b0;
   localparam logic PORT_CORE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RWAIT  = 2'd2,
      ST_DONE   = 2'd3
   } resp_state_t;

   // 2'b10 is deliberately not a request.
   function automatic logic is_mem_req(input logic [1:0] op);
      return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
   endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-requester round-robin arbiter with a single priority pointer.
// Latency: grant is combinational from the request inputs; pointer updates on the clock.
// Backpressure: grants only while i_grant_en is high; requests are simply held by the caller.
// Ports: i_clk, i_rst (async, active-high), i_req_wb/i_req_core, i_grant_en,
//        o_grant_vld, o_grant_port (PORT_WB / PORT_CORE).
module mem_rr_arb2
   import knight_mem_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_wb,
   input  logic i_req_core,
   input  logic i_grant_en,
   output logic o_grant_vld,
   output logic o_grant_port
);

   logic r_ptr;
   logic w_both;

   always_comb begin
      w_both       = i_req_wb && i_req_core;
      o_grant_vld  = i_grant_en && (i_req_wb || i_req_core);
      o_grant_port = PORT_WB;
      if (w_both) begin
         o_grant_port = r_ptr;
      end else if (i_req_core) begin
         o_grant_port = PORT_CORE;
      end
   end

   // The pointer only moves on contention: the loser gets priority next time.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= PORT_WB;
      end else if (i_grant_en && w_both) begin
         r_ptr <= ~r_ptr;
      end
   end

endmodule

// File: rtl/sram_op_responder.sv
// Serves 2-bit mem-op requests from the Wishbone and core ports onto a single-port SRAM.
// Latency: write opdone 2 cycles after the op is sampled, read opdone 2+READ_LATENCY.
// Backpressure: requesters hold op until opdone; a drain flag blocks re-grant until op returns to none.
// Ports: clk, reset (async, active-high); wbctrl_mem_* / core_mem_* request inputs;
//        mem_opdone/sram_data and core_opdone/core_rdata responses; sram_* macro interface;
//        err (sticky out-of-range flag) only when SRAM_BOUNDS_CHECK_EN is defined.
module sram_op_responder
   import knight_mem_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        wbctrl_mem_op,
   input  logic [31:0]       wbctrl_mem_addr,
   input  logic [31:0]       wbctrl_mem_data,
   output logic              mem_opdone,
   output logic [31:0]       sram_data,
   input  logic [1:0]        core_mem_op,
   input  logic [31:0]       core_mem_addr,
   input  logic [31:0]       core_mem_data,
   output logic              core_opdone,
   output logic [31:0]       core_rdata,
   output logic              sram_csb0,
   output logic              sram_web0,
   output logic [3:0]        sram_wmask0,
   output logic [ADDR_W-1:0] sram_addr0,
   output logic [31:0]       sram_din0,
   input  logic [31:0]       sram_dout0
`ifdef SRAM_BOUNDS_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

   resp_state_t       r_state;
   resp_state_t       w_next_state;
   logic              r_port;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic [CNT_W-1:0]  r_lat_cnt;
   logic              r_drain_wb;
   logic              r_drain_core;
   logic [31:0]       r_rdata_wb;
   logic [31:0]       r_rdata_core;

   logic              w_pend_wb;
   logic              w_pend_core;
   logic              w_grant_vld;
   logic              w_grant_port;
   logic [1:0]        w_sel_op;
   logic [31:0]       w_sel_addr;
   logic [31:0]       w_sel_data;
   logic              w_addr_hi;
   logic              w_sel_oob;
   logic              w_rd_last;

   assign w_pend_wb   = is_mem_req(wbctrl_mem_op) && !r_drain_wb;
   assign w_pend_core = is_mem_req(core_mem_op) && !r_drain_core;

   mem_rr_arb2 u_arb (
      .i_clk        (clk),
      .i_rst        (reset),
      .i_req_wb     (w_pend_wb),
      .i_req_core   (w_pend_core),
      .i_grant_en   (r_state == ST_IDLE),
      .o_grant_vld  (w_grant_vld),
      .o_grant_port (w_grant_port)
   );

   assign w_sel_op   = (w_grant_port == PORT_CORE) ? core_mem_op   : wbctrl_mem_op;
   assign w_sel_addr = (w_grant_port == PORT_CORE) ? core_mem_addr : wbctrl_mem_addr;
   assign w_sel_data = (w_grant_port == PORT_CORE) ? core_mem_data : wbctrl_mem_data;

   // Any address bit above the SRAM depth.
   assign w_addr_hi  = |(w_sel_addr >> ADDR_W);

`ifdef SRAM_BOUNDS_CHECK_EN
   logic r_err;
   assign w_sel_oob = w_addr_hi;
   assign err       = r_err;
`else
   logic w_unused_addr_hi;
   assign w_sel_oob        = 1'b0;
   assign w_unused_addr_hi = w_addr_hi;
`endif

   assign w_rd_last = (r_state == ST_RWAIT) && (r_lat_cnt == CNT_LAST);

   // Next state and SRAM/response outputs.
   always_comb begin
      w_next_state = r_state;
      sram_csb0    = 1'b1;
      sram_web0    = 1'b1;
      sram_wmask0  = 4'h0;
      sram_addr0   = r_addr;
      sram_din0    = r_data;
      mem_opdone   = 1'b0;
      core_opdone  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_vld) begin
               w_next_state = w_sel_oob ? ST_DONE : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            sram_csb0 = 1'b0;
            if (r_write) begin
               sram_web0    = 1'b0;
               sram_wmask0  = 4'hF;
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            if (w_rd_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            mem_opdone   = (r_port == PORT_WB);
            core_opdone  = (r_port == PORT_CORE);
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_port       <= PORT_WB;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_lat_cnt    <= '0;
         r_drain_wb   <= 1'b0;
         r_drain_core <= 1'b0;
         r_rdata_wb   <= '0;
         r_rdata_core <= '0;
`ifdef SRAM_BOUNDS_CHECK_EN
         r_err        <= 1'b0;
`endif
      end else begin
         r_state <= w_next_state;

         if ((r_state == ST_IDLE) && w_grant_vld) begin
            r_port  <= w_grant_port;
            r_write <= (w_sel_op == MEM_OP_WRITE);
            r_addr  <= w_sel_addr[ADDR_W-1:0];
            r_data  <= w_sel_data;
`ifdef SRAM_BOUNDS_CHECK_EN
            // Out-of-range: reads return zero, writes are dropped, flag sticks.
            if (w_sel_oob) begin
               r_err <= 1'b1;
               if (w_sel_op == MEM_OP_READ) begin
                  if (w_grant_port == PORT_CORE) r_rdata_core <= '0;
                  else                           r_rdata_wb   <= '0;
               end
            end
`endif
         end

         if (r_state == ST_ACCESS) begin
            r_lat_cnt <= '0;
         end else if (r_state == ST_RWAIT) begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
         end

         if (w_rd_last) begin
            if (r_port == PORT_CORE) r_rdata_core <= sram_dout0;
            else                     r_rdata_wb   <= sram_dout0;
         end

         // Set on completion; cleared once the requester has let go of op.
         if ((r_state == ST_DONE) && (r_port == PORT_WB)) begin
            r_drain_wb <= 1'b1;
         end else if (!is_mem_req(wbctrl_mem_op)) begin
            r_drain_wb <= 1'b0;
         end
         if ((r_state == ST_DONE) && (r_port == PORT_CORE)) begin
            r_drain_core <= 1'b1;
         end else if (!is_mem_req(core_mem_op)) begin
            r_drain_core <= 1'b0;
         end
      end
   end

   assign sram_data  = r_rdata_wb;
   assign core_rdata = r_rdata_core;

endmodule

// File: tb/tb_sram_op_responder.sv
// Bench for sram_op_responder: directed vector table, corner sequences, randomized run
// against a word-array memory model. Behavioural SRAM with one cycle read latency.
// Covers both builds (SRAM_BOUNDS_CHECK_EN defined or not).
module tb_sram_op_responder;
   import knight_mem_pkg::*;

   localparam int AW = 8;
   localparam int RL = 1;
`ifdef SRAM_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    wb_op, core_op;
   logic [31:0]   wb_addr, wb_data, core_addr, core_data;
   logic          mem_opdone, core_opdone;
   logic [31:0]   sram_data, core_rdata;
   logic          csb, web;
   logic [3:0]    wmask;
   logic [AW-1:0] saddr;
   logic [31:0]   din, dout;
`ifdef SRAM_BOUNDS_CHECK_EN
   logic          err;
`endif

   always #5 clk = ~clk;

   sram_op_responder #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
      .clk             (clk),
      .reset           (reset),
      .wbctrl_mem_op   (wb_op),
      .wbctrl_mem_addr (wb_addr),
      .wbctrl_mem_data (wb_data),
      .mem_opdone      (mem_opdone),
      .sram_data       (sram_data),
      .core_mem_op     (core_op),
      .core_mem_addr   (core_addr),
      .core_mem_data   (core_data),
      .core_opdone     (core_opdone),
      .core_rdata      (core_rdata),
      .sram_csb0       (csb),
      .sram_web0       (web),
      .sram_wmask0     (wmask),
      .sram_addr0      (saddr),
      .sram_din0       (din),
      .sram_dout0      (dout)
`ifdef SRAM_BOUNDS_CHECK_EN
      ,
      .err             (err)
`endif
   );

   // Behavioural SRAM macro.
   logic [31:0] sram_mem [0:(1<<AW)-1];
   logic [31:0] wm;
   always_comb wm = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
   always @(posedge clk) begin
      if (!csb) begin
         if (!web) sram_mem[saddr] <= (sram_mem[saddr] & ~wm) | (din & wm);
         else      dout <= sram_mem[saddr];
      end
   end

   int n_access = 0, n_wb_done = 0, n_core_done = 0;
   always @(negedge clk) begin
      if (!csb) n_access++;
      if (mem_opdone) n_wb_done++;
      if (core_opdone) n_core_done++;
   end

   int total = 0, bad = 0;
   logic [31:0] ref_mem [0:(1<<AW)-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic bit is_oob(input logic [31:0] a);
      return (a >> AW) != 0;
   endfunction

   task automatic set_port(input bit p, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] d);
      if (p) begin core_op = op; core_addr = a; core_data = d; end
      else   begin wb_op   = op; wb_addr   = a; wb_data   = d; end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " mem_opdone"},  {31'd0, mem_opdone}, 0);
      chk({tag, " core_opdone"}, {31'd0, core_opdone}, 0);
      chk({tag, " sram_data"},   sram_data, 0);
      chk({tag, " core_rdata"},  core_rdata, 0);
      chk({tag, " csb"},         {31'd0, csb}, 1);
      chk({tag, " web"},         {31'd0, web}, 1);
      chk({tag, " wmask"},       {28'd0, wmask}, 0);
      chk({tag, " addr"},        {24'd0, saddr}, 0);
      chk({tag, " din"},         din, 0);
`ifdef SRAM_BOUNDS_CHECK_EN
      chk({tag, " err"},         {31'd0, err}, 0);
`endif
   endtask

   // One op on one port with the other idle; lat = cycle of opdone, zero if it never came.
   task automatic do_op(input bit p, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd);
      logic [31:0] ia;
      ia  = a;
      lat = 0;
      rd  = 0;
      set_port(p, op, a, d);
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (lat == 0 && (p ? core_opdone : mem_opdone)) begin
            lat = n;
            rd  = p ? core_rdata : sram_data;
         end
         if (lat != 0 && n == lat) n = 12;
      end
      if (lat != 0 && op == MEM_OP_WRITE && !(BOUNDS && is_oob(a)))
         ref_mem[ia[AW-1:0]] = d;
      if (lat != 0) begin @(posedge clk); #1; end
      set_port(p, MEM_OP_NONE, 0, 0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mkv(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] d, input int lat, input logic [31:0] rd);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.lat = lat; v.rdata = rd;
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[$];
      int          lat, t_wb, t_core, s_acc, s_done;
      logic [31:0] rd;
      int          ph[2], cnt[2], wt[2];
      logic [1:0]  rop[2];
      logic [31:0] raddr[2], rdat[2], last_rd[2];
      int          exp_acc, n_cmp;
      bit          exp_err;

      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 'x;
      reset = 1'b0;
      set_port(0, MEM_OP_NONE, 0, 0);
      set_port(1, MEM_OP_NONE, 0, 0);
      #3 reset = 1'b1;
      #1 chk_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Directed table, run on each port.
      vecs.push_back(mkv(MEM_OP_WRITE, 32'h5,  32'hDEADBEEF, 2, 0));
      vecs.push_back(mkv(MEM_OP_READ,  32'h5,  0, 2+RL, 32'hDEADBEEF));
      vecs.push_back(mkv(MEM_OP_WRITE, 32'h0,  32'h00000001, 2, 0));
      vecs.push_back(mkv(MEM_OP_WRITE, 32'hFF, 32'hA5A55A5A, 2, 0));
      vecs.push_back(mkv(MEM_OP_READ,  32'h0,  0, 2+RL, 32'h00000001));
      vecs.push_back(mkv(MEM_OP_READ,  32'hFF, 0, 2+RL, 32'hA5A55A5A));
      vecs.push_back(mkv(2'b10,        32'h0,  0, 0, 0));
`ifdef SRAM_BOUNDS_CHECK_EN
      vecs.push_back(mkv(MEM_OP_READ,  32'h100, 0, 1, 0));
      vecs.push_back(mkv(MEM_OP_WRITE, 32'h105, 32'h12345678, 1, 0));
      vecs.push_back(mkv(MEM_OP_READ,  32'h5,  0, 2+RL, 32'hDEADBEEF));
`else
      vecs.push_back(mkv(MEM_OP_WRITE, 32'h105, 32'h12345678, 2, 0));
      vecs.push_back(mkv(MEM_OP_READ,  32'h5,  0, 2+RL, 32'h12345678));
      vecs.push_back(mkv(MEM_OP_READ,  32'h1FF, 0, 2+RL, 32'hA5A55A5A));
`endif
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < vecs.size(); i++) begin
            do_op(p[0], vecs[i].op, vecs[i].addr, vecs[i].data, lat, rd);
            chk($sformatf("vec%0d port%0d latency", i, p), lat, vecs[i].lat);
            if (vecs[i].op == MEM_OP_READ)
               chk($sformatf("vec%0d port%0d rdata", i, p), rd, vecs[i].rdata);
         end
      end

      // Simultaneous writes after reset: Wishbone first, core after its DONE.
      #2 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      set_port(0, MEM_OP_WRITE, 32'h1, 32'h11);
      set_port(1, MEM_OP_WRITE, 32'h2, 32'h22);
      t_wb = 0; t_core = 0;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         if (t_wb != 0 && n == t_wb + 1) set_port(0, MEM_OP_NONE, 0, 0);
         if (t_core != 0 && n == t_core + 1) set_port(1, MEM_OP_NONE, 0, 0);
         if (mem_opdone && t_wb == 0) t_wb = n;
         if (core_opdone && t_core == 0) t_core = n;
      end
      chk("simul wb opdone cycle", t_wb, 2);
      chk("simul core opdone cycle", t_core, 5);
      ref_mem[1] = 32'h11; ref_mem[2] = 32'h22;
      do_op(1, MEM_OP_READ, 32'h1, 0, lat, rd);
      chk("simul readback addr1", rd, 32'h11);
      do_op(0, MEM_OP_READ, 32'h2, 0, lat, rd);
      chk("simul readback addr2", rd, 32'h22);

      // Drain: core holds its read op for 4 cycles after opdone.
      s_acc = n_access; s_done = n_core_done;
      set_port(1, MEM_OP_READ, 32'h1, 0);
      lat = 0;
      for (int n = 1; n <= 12 && lat == 0; n++) begin
         @(posedge clk); #1;
         if (core_opdone) lat = n;
      end
      chk("drain first opdone cycle", lat, 2+RL);
      repeat (4) begin @(posedge clk); #1; end
      set_port(1, MEM_OP_NONE, 0, 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("drain sram accesses", n_access - s_acc, 1);
      chk("drain core_opdone pulses", n_core_done - s_done, 1);
      chk("drain core_rdata", core_rdata, 32'h11);

`ifdef SRAM_BOUNDS_CHECK_EN
      s_acc = n_access;
      do_op(0, MEM_OP_READ, 32'h100, 0, lat, rd);
      chk("bounds latency", lat, 1);
      chk("bounds rdata", rd, 0);
      chk("bounds err", {31'd0, err}, 1);
      chk("bounds no sram access", n_access - s_acc, 0);
`endif

      // Reset in RWAIT: everything back to reset values at once, request re-served.
      set_port(0, MEM_OP_READ, 32'h2, 0);
      @(posedge clk); #1;
      chk("midreset access csb", {31'd0, csb}, 0);
      @(posedge clk); #1;
      s_done = n_wb_done;
      reset = 1'b1;
      #1 chk_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1 chk("midreset no opdone", n_wb_done - s_done, 0);
      reset = 1'b0;
      lat = 0;
      for (int n = 1; n <= 12 && lat == 0; n++) begin
         @(posedge clk); #1;
         if (mem_opdone) begin lat = n; rd = sram_data; end
      end
      chk("midreset completes", {31'd0, lat != 0}, 1);
      chk("midreset rdata", rd, 32'h22);
      @(posedge clk); #1;
      set_port(0, MEM_OP_NONE, 0, 0);
      @(posedge clk); #1;

      // Preload low addresses, then randomized two-port traffic.
      for (int i = 0; i < 16; i++) begin
         do_op(i[0], MEM_OP_WRITE, i, $urandom, lat, rd);
         chk("preload write latency", lat, 2);
      end
      #2 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      for (int p = 0; p < 2; p++) begin
         ph[p] = 0; cnt[p] = $urandom_range(0, 3); wt[p] = 0;
         rop[p] = MEM_OP_NONE; raddr[p] = 0; rdat[p] = 0; last_rd[p] = 0;
      end
      s_acc = n_access; exp_acc = 0; exp_err = 1'b0; n_cmp = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            logic        done;
            logic [31:0] rdv, ra;
            done = p[0] ? core_opdone : mem_opdone;
            rdv  = p[0] ? core_rdata : sram_data;
            if (ph[p] == 1) begin
               if (done) begin
                  ra = raddr[p];
                  if (rop[p] == MEM_OP_READ) begin
                     last_rd[p] = (BOUNDS && is_oob(ra)) ? 32'h0 : ref_mem[ra[AW-1:0]];
                     chk($sformatf("rand port%0d rdata", p), rdv, last_rd[p]);
                  end else if (!(BOUNDS && is_oob(ra))) begin
                     ref_mem[ra[AW-1:0]] = rdat[p];
                  end
                  if (BOUNDS && is_oob(ra)) exp_err = 1'b1;
                  else exp_acc++;
                  chk($sformatf("rand port%0d wait bound", p), {31'd0, wt[p] <= 12}, 1);
                  n_cmp++;
                  ph[p] = 2; cnt[p] = $urandom_range(0, 3);
               end else begin
                  wt[p]++;
                  if (wt[p] > 30) begin
                     chk($sformatf("rand port%0d opdone timeout", p), 0, 1);
                     set_port(p[0], MEM_OP_NONE, 0, 0);
                     ph[p] = 0; cnt[p] = 2;
                  end
               end
            end else begin
               chk($sformatf("rand port%0d spurious opdone", p), {31'd0, done}, 0);
               if (cnt[p] != 0) begin
                  cnt[p]--;
               end else if (ph[p] == 2) begin
                  set_port(p[0], MEM_OP_NONE, 0, 0);
                  ph[p] = 0; cnt[p] = $urandom_range(0, 3);
               end else begin
                  rop[p]   = $urandom_range(0, 1) ? MEM_OP_WRITE : MEM_OP_READ;
                  raddr[p] = $urandom_range(0, 15);
                  if ($urandom_range(0, 7) == 0)
                     raddr[p] = raddr[p] | (32'h1 << $urandom_range(AW, 31));
                  rdat[p]  = $urandom;
                  set_port(p[0], rop[p], raddr[p], rdat[p]);
                  ph[p] = 1; wt[p] = 0;
               end
            end
            if (!done) chk($sformatf("rand port%0d rdata hold", p), rdv, last_rd[p]);
         end
      end
      @(negedge clk);
      chk("rand sram access count", n_access - s_acc, exp_acc);
      chk("rand enough completions", {31'd0, n_cmp > 100}, 1);
`ifdef SRAM_BOUNDS_CHECK_EN
      chk("rand err flag", {31'd0, err}, {31'd0, exp_err});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
